// File: rtl/vsc_pkg.sv
// Shared types and constants for the VerySimpleCPU memory-port blocks.
package vsc_pkg;

    localparam int VSC_DATA_W       = 32;
    localparam int VSC_DEFAULT_SIZE = 14;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/vsc_dma_addr_gen.sv
// Source/destination pointers and remaining word count for vsc_dma_copy.
// VSC_DMA_OVERLAP_EN selects a descending walk for overlapping forward moves.
module vsc_dma_addr_gen
    import vsc_pkg::*;
#(
    parameter int SIZE = VSC_DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [SIZE-1:0] src_addr,
    input  logic [SIZE-1:0] dst_addr,
    input  logic [SIZE:0]   len,
    output logic [SIZE-1:0] src_d,
    output logic [SIZE-1:0] dst_d,
    output logic            last
);

    logic [SIZE-1:0] src_q;
    logic [SIZE-1:0] dst_q;
    logic [SIZE:0]   cnt_q;
    logic            desc_q;
    logic            desc_start;
    logic [SIZE-1:0] span;

    // Offset of the final word; len = 2^SIZE wraps to 2^SIZE-1 as intended.
    assign span = SIZE'(len - 1'b1);

`ifdef VSC_DMA_OVERLAP_EN
    logic [SIZE-1:0] gap;
    assign gap        = dst_addr - src_addr;
    assign desc_start = (gap != '0) && ({1'b0, gap} < len);
`else
    assign desc_start = 1'b0;
`endif

    // src_d/dst_d are the pointer values after this edge, so the FSM can
    // register the next RAM address in the same cycle the pointers change.
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        if (load) begin
            src_d = desc_start ? src_addr + span : src_addr;
            dst_d = desc_start ? dst_addr + span : dst_addr;
        end else if (step) begin
            src_d = desc_q ? src_q - 1'b1 : src_q + 1'b1;
            dst_d = desc_q ? dst_q - 1'b1 : dst_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            desc_q <= 1'b0;
        end else begin
            src_q <= src_d;
            dst_q <= dst_d;
            if (load) begin
                cnt_q  <= len;
                desc_q <= desc_start;
            end else if (step) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign last = (cnt_q == (SIZE+1)'(1));

endmodule

// File: rtl/vsc_dma_copy.sv
// Block copy engine on the single-port blram interface (RD/WAIT/WR per word).
// Build option: VSC_DMA_OVERLAP_EN enables memmove-safe descending copies.
module vsc_dma_copy
    import vsc_pkg::*;
#(
    parameter int SIZE = VSC_DEFAULT_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SIZE-1:0]       src_addr,
    input  logic [SIZE-1:0]       dst_addr,
    input  logic [SIZE:0]         len,
    output logic                  busy,
    output logic                  done,
    output logic                  wrEn,
    output logic [SIZE-1:0]       addr_toRAM,
    output logic [VSC_DATA_W-1:0] data_toRAM,
    input  logic [VSC_DATA_W-1:0] data_fromRAM,
    output dma_state_e            dbg_state
);

    // Handshake: start is a request taken only in IDLE; busy then covers every
    // cycle the block owns the RAM port, and done pulses once when it lets go.
    dma_state_e      state;
    dma_state_e      state_n;
    logic            load;
    logic            step;
    logic            last;
    logic [SIZE-1:0] src_d;
    logic [SIZE-1:0] dst_d;

    vsc_dma_addr_gen #(.SIZE(SIZE)) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .src_d    (src_d),
        .dst_d    (dst_d),
        .last     (last)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = (len == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD:   state_n = ST_WAIT;
            ST_WAIT: state_n = ST_WR;
            ST_WR: begin
                step    = 1'b1;
                state_n = last ? ST_DONE : ST_RD;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Port outputs are registered from state_n so they line up with the state
    // they belong to; data_toRAM itself serves as the word buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrEn       <= 1'b0;
            addr_toRAM <= '0;
            data_toRAM <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n == ST_RD) || (state_n == ST_WAIT) || (state_n == ST_WR);
            done  <= (state_n == ST_DONE);
            wrEn  <= (state_n == ST_WR);
            if (state_n == ST_RD) begin
                addr_toRAM <= src_d;
            end else if (state_n == ST_WR) begin
                addr_toRAM <= dst_d;
            end
            if (state == ST_WAIT) begin
                data_toRAM <= data_fromRAM;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_vsc_dma_copy.sv
// Randomized and directed bench for vsc_dma_copy against a word-level copy model.
// Honors VSC_DMA_OVERLAP_EN the same way as the design build.
module tb_vsc_dma_copy;
    import vsc_pkg::*;

    localparam int SIZE = 14;
    localparam int N    = 1 << SIZE;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic [SIZE-1:0]   src_addr = '0;
    logic [SIZE-1:0]   dst_addr = '0;
    logic [SIZE:0]     len = '0;
    logic              busy;
    logic              done;
    logic              wrEn;
    logic [SIZE-1:0]   addr_toRAM;
    logic [31:0]       data_toRAM;
    logic [31:0]       data_fromRAM;
    dma_state_e        dbg_state;

    vsc_dma_copy #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .busy         (busy),
        .done         (done),
        .wrEn         (wrEn),
        .addr_toRAM   (addr_toRAM),
        .data_toRAM   (data_toRAM),
        .data_fromRAM (data_fromRAM),
        .dbg_state    (dbg_state)
    );

    // blram: registered read, write on wrEn
    logic [31:0] ram     [N];
    logic [31:0] ref_mem [N];
    always @(posedge clk) begin
        data_fromRAM <= ram[addr_toRAM];
        if (wrEn) ram[addr_toRAM] <= data_toRAM;
    end

    // scoreboard
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic poke(input int a, input logic [31:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic compare_mem(input int d, input int l, input string tag);
        int diffs;
        for (int i = 0; i < l; i++) exp_q.push_back(ref_mem[(d + i) % N]);
        for (int i = 0; i < l; i++) check({tag, "_dst"}, ram[(d + i) % N], exp_q.pop_front());
        diffs = 0;
        for (int a = 0; a < N; a++) if (ram[a] !== ref_mem[a]) diffs++;
        check({tag, "_mem_all_diffs"}, diffs, 0);
    endtask

    // driver + cycle-accurate reference; restart_k / abort_k = 0 disables
    task automatic run_copy(input int s, input int d, input int l,
                            input int restart_k, input int abort_k, input string tag);
        int  gap;
        bit  desc;
        int  idx, ra, wa, ph, wi;
        logic [31:0] wexp;
        gap  = ((d - s) % N + N) % N;
`ifdef VSC_DMA_OVERLAP_EN
        desc = (gap != 0) && (gap < l);
`else
        desc = 1'b0;
`endif
        @(negedge clk);
        start    = 1'b1;
        src_addr = SIZE'(s);
        dst_addr = SIZE'(d);
        len      = (SIZE+1)'(l);
        @(posedge clk);
        for (int k = 1; k <= 3 * l + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start    = 1'b0;
                src_addr = SIZE'($urandom);
                dst_addr = SIZE'($urandom);
                len      = (SIZE+1)'($urandom_range(1, 5));
            end
            if (restart_k != 0 && k == restart_k + 1) start = 1'b0;
            wi  = (k - 1) / 3;
            ph  = (k - 1) % 3;
            idx = desc ? (l - 1 - wi) : wi;
            ra  = (s + idx) % N;
            wa  = (d + idx) % N;
            if (l > 0 && k <= 3 * l) begin
                check({tag, "_busy"}, busy, 1);
                check({tag, "_done_early"}, done, 0);
                if (ph == 0) begin
                    check({tag, "_rd_addr"}, addr_toRAM, ra);
                    check({tag, "_rd_wren"}, wrEn, 0);
                end else if (ph == 1) begin
                    check({tag, "_wait_wren"}, wrEn, 0);
                end else begin
                    wexp = ref_mem[ra];
                    check({tag, "_wr_wren"}, wrEn, 1);
                    check({tag, "_wr_addr"}, addr_toRAM, wa);
                    check({tag, "_wr_data"}, data_toRAM, wexp);
                    ref_mem[wa] = wexp;
                end
            end else if (k == 3 * l + 1) begin
                check({tag, "_done"}, done, 1);
                check({tag, "_done_busy"}, busy, 0);
                check({tag, "_done_wren"}, wrEn, 0);
            end else begin
                check({tag, "_post_done"}, done, 0);
                check({tag, "_post_busy"}, busy, 0);
                check({tag, "_post_wren"}, wrEn, 0);
            end
            if (restart_k != 0 && k == restart_k) begin
                start    = 1'b1;
                dst_addr = SIZE'(400);
            end
            if (abort_k != 0 && k == abort_k) begin
                rst = 1'b0;
                @(negedge clk);
                check({tag, "_abort_busy"}, busy, 0);
                check({tag, "_abort_wren"}, wrEn, 0);
                check({tag, "_abort_done"}, done, 0);
                rst = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    check({tag, "_abort_no_done"}, done, 0);
                    check({tag, "_abort_no_busy"}, busy, 0);
                end
                break;
            end
        end
        compare_mem(d, l, tag);
    endtask

    initial begin
        int s, d, l;
        for (int a = 0; a < N; a++) poke(a, $urandom);

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wren", wrEn, 0);
        check("rst_addr", addr_toRAM, 0);
        check("rst_data", data_toRAM, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b1;

        poke(69, 32'd1);
        poke(70, 32'h3E8);
        run_copy(69, 200, 2, 0, 0, "basic");
        check("basic_m200", ram[200], 32'd1);
        check("basic_m201", ram[201], 32'h3E8);

        run_copy(123, 456, 0, 0, 0, "len0");

        poke(16382, 32'hAAAA_0001);
        poke(16383, 32'hBBBB_0002);
        poke(0, 32'hCCCC_0003);
        poke(1, 32'hDDDD_0004);
        run_copy(16382, 500, 4, 0, 0, "wrap");
        check("wrap_m503", ram[503], 32'hDDDD_0004);

        poke(100, 32'd6);
        poke(101, 32'd0);
        poke(102, 32'd9);
        run_copy(100, 101, 2, 0, 0, "overlap");
        check("overlap_m101", ram[101], 32'd6);
`ifdef VSC_DMA_OVERLAP_EN
        check("overlap_m102", ram[102], 32'd0);
`else
        check("overlap_m102", ram[102], 32'd6);
`endif

        run_copy(69, 300, 3, 2, 0, "restart");
        run_copy(69, 600, 3, 0, 4, "abort");
        run_copy(700, 800, 3, 0, 0, "after_abort");

        for (int t = 0; t < 20; t++) begin
            s = $urandom_range(0, N - 1);
            l = $urandom_range(0, 10);
            if ($urandom_range(0, 2) == 0) d = (s + $urandom_range(1, l + 1)) % N;
            else if ($urandom_range(0, 1) == 0) d = (s + N - $urandom_range(1, l + 1)) % N;
            else d = $urandom_range(0, N - 1);
            run_copy(s, d, l, 0, 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
